// File: rtl/sysbus_mem_responder_if.sv
// Sysbus request/response channel between an initiator (master) and a
// memory-style responder (slave).
interface sysbus_mem_responder_if #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13
);
  logic                      bus_reqcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_req;
  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag;
  logic                      bus_reqack;
  logic                      bus_respcyc;
  logic [BUS_DATA_WIDTH-1:0] bus_resp;
  logic [BUS_TAG_WIDTH-1:0]  bus_resptag;
  logic                      bus_respack;

  modport master (
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );

  modport slave (
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );
endinterface

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory responder: 8-beat line writes and 8-beat line reads against
// an on-chip word array. Reads return the line after a fixed delay, beats in
// ascending order, each beat held until the initiator acknowledges it.
module sysbus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 4096,
  parameter int LATENCY        = 4
) (
  input logic                   clk,
  input logic                   reset,
  sysbus_mem_responder_if.slave bus
);

  // Sysbus device code of the MEMORY target in tag bits 11:8.
  localparam logic [3:0] MEMORY_DEV = 4'b0001;
  localparam int LINES  = MEM_WORDS / 8;
  localparam int LINE_W = (LINES > 1) ? $clog2(LINES) : 1;

  typedef enum logic [1:0] {IDLE, WDATA, DELAY, RESP} state_t;

  state_t                     state_reg;
  logic [LINE_W-1:0]          line_reg;
  logic [2:0]                 beat_reg;
  logic [3:0]                 delay_reg;
  logic [BUS_TAG_WIDTH-1:0]   tag_reg;
  logic                       respcyc_reg;
  logic [BUS_DATA_WIDTH-1:0]  resp_reg;
  logic [BUS_TAG_WIDTH-1:0]   resptag_reg;
  logic                       reqack_next;

  logic [BUS_DATA_WIDTH-1:0]  mem [MEM_WORDS];

  logic                       addressed;
  logic                       is_read;
  logic [LINE_W-1:0]          req_line;

  assign addressed = (bus.bus_reqtag[11:8] == MEMORY_DEV);
  assign is_read   = bus.bus_reqtag[12];
  // 64-byte lines; offset bits 5:0 never select a starting beat.
  assign req_line  = LINE_W'((bus.bus_req >> 6) % BUS_DATA_WIDTH'(LINES));

  // Acknowledge is combinational so a beat is accepted in the very cycle it
  // is presented; only IDLE (new request) and WDATA (data beats) accept.
  always_comb begin
    reqack_next = 1'b0;
    if (reset) begin
      case (state_reg)
        IDLE:    reqack_next = bus.bus_reqcyc && addressed;
        WDATA:   reqack_next = bus.bus_reqcyc;
        default: reqack_next = 1'b0;
      endcase
    end
  end

  assign bus.bus_reqack  = reqack_next;
  assign bus.bus_respcyc = respcyc_reg;
  assign bus.bus_resp    = resp_reg;
  assign bus.bus_resptag = resptag_reg;

  // Storage write port: one word per accepted write data beat; storage is
  // never cleared, so contents survive reset.
  always_ff @(posedge clk) begin
    if (reset && state_reg == WDATA && bus.bus_reqcyc) begin
      mem[{line_reg, beat_reg}] <= bus.bus_req;
    end
  end

  // Transaction sequencer with registered response outputs; the read data
  // register is loaded one cycle ahead so each beat is valid with respcyc.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= IDLE;
      line_reg    <= '0;
      beat_reg    <= '0;
      delay_reg   <= '0;
      tag_reg     <= '0;
      respcyc_reg <= 1'b0;
      resp_reg    <= '0;
      resptag_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.bus_reqcyc && addressed) begin
            line_reg <= req_line;
            beat_reg <= 3'd0;
            if (is_read) begin
              tag_reg   <= bus.bus_reqtag;
              // DELAY is occupied for LATENCY cycles: counts LATENCY-1 .. 0.
              delay_reg <= 4'(LATENCY - 1);
              state_reg <= DELAY;
            end else begin
              state_reg <= WDATA;
            end
          end
        end
        WDATA: begin
          if (bus.bus_reqcyc) begin
            beat_reg <= beat_reg + 3'd1;
            if (beat_reg == 3'd7) begin
              state_reg <= IDLE;
            end
          end
        end
        DELAY: begin
          if (delay_reg == 4'd0) begin
            state_reg   <= RESP;
            respcyc_reg <= 1'b1;
            resp_reg    <= mem[{line_reg, 3'd0}];
            resptag_reg <= tag_reg;
          end else begin
            delay_reg <= delay_reg - 4'd1;
          end
        end
        RESP: begin
          if (bus.bus_respack) begin
            if (beat_reg == 3'd7) begin
              state_reg   <= IDLE;
              beat_reg    <= 3'd0;
              respcyc_reg <= 1'b0;
              resp_reg    <= '0;
              resptag_reg <= '0;
            end else begin
              beat_reg <= beat_reg + 3'd1;
              resp_reg <= mem[{line_reg, beat_reg + 3'd1}];
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sysbus_mem_responder.md
SYSBUS_MEM_RESPONDER -- requirements
Module: sysbus_mem_responder

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 64, bus data/address width.
REQ-002 SHALL have parameter BUS_TAG_WIDTH, default 13, bus tag width.
REQ-003 SHALL have parameter MEM_WORDS, default 4096, number of 64-bit storage words (a multiple of 8).
REQ-004 SHALL have parameter LATENCY, default 4, cycles from read accept to first response beat (range 1-15).
REQ-005 SHALL have port clk  input  1  clock.
REQ-006 SHALL have port reset  input  1  reset: synchronous, active-low; clock clk.
REQ-007 SHALL have port bus_reqcyc  input  1  request valid from initiator.
REQ-008 SHALL have port bus_req  input  BUS_DATA_WIDTH  request address beat or write data beat.
REQ-009 SHALL have port bus_reqtag  input  BUS_TAG_WIDTH  request tag: bit 12 = 1 read / 0 write; bits 11:8 = device; bits 7:0 = 0.
REQ-010 SHALL have port bus_reqack  output  1  request beat accepted.
REQ-011 SHALL have port bus_respcyc  output  1  response beat valid.
REQ-012 SHALL have port bus_resp  output  BUS_DATA_WIDTH  response data beat.
REQ-013 SHALL have port bus_resptag  output  BUS_TAG_WIDTH  echo of accepted request tag.
REQ-014 SHALL have port bus_respack  input  1  initiator consumed current response beat.

Function
REQ-015 SHALL implement states IDLE, WDATA, DELAY, RESP, one active per cycle.
REQ-016 SHALL treat a request as addressed to it only when tag device field equals the Sysbus MEMORY device code; other requests are never acknowledged.
REQ-017 SHALL, in IDLE with bus_reqcyc=1 and a read tag, latch line index = (bus_req>>6) mod (MEM_WORDS/8) and the tag, pulse bus_reqack=1 for exactly that cycle, load the delay counter, go to DELAY.
REQ-018 SHALL, in IDLE with bus_reqcyc=1 and a write tag, latch line index, pulse bus_reqack, clear beat counter, go to WDATA.
REQ-019 SHALL, in WDATA, on each cycle with bus_reqcyc=1 write bus_req to word line*8+beat, assert bus_reqack that cycle, increment beat; after beat 7 go to IDLE; cycles with bus_reqcyc=0 stall with bus_reqack=0.
REQ-020 SHALL produce no response beats for writes.
REQ-021 SHALL stay in DELAY exactly LATENCY cycles, then enter RESP with beat=0.
REQ-022 SHALL, in RESP, drive bus_respcyc=1, bus_resp=mem[line*8+beat], bus_resptag=latched tag, holding all stable until bus_respack=1 is sampled.
REQ-023 SHALL advance beat on each cycle bus_respack=1 in RESP; new beat data valid the next cycle (bus_respcyc stays 1, no bubble).
REQ-024 SHALL, on bus_respack=1 with beat=7, deassert bus_respcyc next cycle and return to IDLE; beat counter wraps 7->0.
REQ-025 SHALL return beats in ascending word order 0..7 regardless of bus_req bits 5:0 (ignored).
REQ-026 SHALL ignore bus_respack outside RESP.
REQ-027 SHALL not acknowledge new requests outside IDLE; a held bus_reqcyc is accepted on the first IDLE cycle.
REQ-028 SHALL drive bus_resp=0 and bus_resptag=0 whenever bus_respcyc=0.
REQ-029 SHALL allow a new request to be accepted in the cycle after returning to IDLE (one idle cycle minimum between transactions).

Reset
REQ-030 SHALL, when reset=0 at a clk edge, enter IDLE and set bus_reqack=0, bus_respcyc=0, bus_resp=0, bus_resptag=0, beat and delay counters 0.
REQ-031 SHALL abort any in-progress read or write on reset; words already written remain, storage is not cleared.
REQ-032 SHALL ignore all bus inputs while reset=0.

Verification
REQ-033 Read at 0x40 with mem[8..15]=0x1000..0x1007, respack held 1 -> reqack pulse 1 cycle, first respcyc LATENCY cycles later, beats 0x1000..0x1007 on 8 consecutive cycles, resptag = request tag.
REQ-034 Same read, respack asserted every 3rd cycle -> each beat held stable until acked, no beat skipped or repeated.
REQ-035 Write 0xA0..0xA7 to 0x80 (with 2-cycle reqcyc gap mid-burst), then read 0x80 -> reads return 0xA0..0xA7; no respcyc during write.
REQ-036 Read with device field != MEMORY, reqcyc held 20 cycles -> reqack and respcyc stay 0.
REQ-037 reset=0 asserted during beat 3 of a read -> next cycle respcyc=0, state IDLE; subsequent read of same line returns unchanged data.
REQ-038 Read at 0x40 + MEM_WORDS*8 and at 0x47 -> same data as read at 0x40 (wrap, low bits ignored).
